harmonic_extractor: RTL

HARMONIC_EXTRACTOR -- requirements
Module: harmonic_extractor

---
 rtl/harmonic_extractor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/harmonic_extractor.sv
// Frame-based harmonic extractor: captures one FFT magnitude frame, finds the
// fundamental bin in the lower half-spectrum and reports magnitudes at k1..5*k1.
module harmonic_extractor #(
  parameter int FFT_N = 1024,
  parameter int DW    = 32,
  parameter int KW    = 10,
  parameter int KMIN  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mag_valid,
  input  logic [KW-1:0] mag_index,
  input  logic [DW-1:0] mag_data,
  output logic [KW-1:0] k1,
  output logic [DW-1:0] h1,
  output logic [DW-1:0] h2,
  output logic [DW-1:0] h3,
  output logic [DW-1:0] h4,
  output logic [DW-1:0] h5,
  output logic          harm_valid,
  output logic          busy,
  output logic          frame_err,
  output logic          drop
);

  typedef enum logic [1:0] {SYNC, CAPTURE, FETCH, DONE} state_t;

  localparam logic [KW-1:0] LAST_IDX = KW'(FFT_N - 1);
  localparam logic [KW:0]   SRCH_LO  = (KW+1)'(KMIN);
  localparam logic [KW:0]   SRCH_HI  = (KW+1)'(FFT_N / 2 - 1);
  localparam logic [KW+2:0] HARM_MAX = (KW+3)'(FFT_N / 2 - 1);

  logic [DW-1:0] mem [FFT_N];

  state_t        state_q, state_d;
  logic [KW-1:0] exp_q, exp_d;
  logic [KW-1:0] pk_idx_q, pk_idx_d;
  logic [DW-1:0] pk_val_q, pk_val_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic          rd_ok_q, rd_ok_d;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] t2_q, t2_d, t3_q, t3_d, t4_q, t4_d;
  logic [KW-1:0] k1_q, k1_d;
  logic [DW-1:0] h1_q, h1_d, h2_q, h2_d, h3_q, h3_d, h4_q, h4_d, h5_q, h5_d;
  logic          harm_valid_q, harm_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          drop_q, drop_d;

  logic          start, accept, wr_en, in_rng;
  logic [KW+2:0] prod;
  logic [KW-1:0] rd_addr;
  logic [DW-1:0] rd_val, pk_base;

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    pk_idx_d     = pk_idx_q;
    pk_val_d     = pk_val_q;
    fcnt_d       = fcnt_q;
    rd_ok_d      = 1'b0;
    t2_d         = t2_q;
    t3_d         = t3_q;
    t4_d         = t4_q;
    k1_d         = k1_q;
    h1_d         = h1_q;
    h2_d         = h2_q;
    h3_d         = h3_q;
    h4_d         = h4_q;
    h5_d         = h5_q;
    harm_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    drop_d       = 1'b0;
    start        = 1'b0;
    accept       = 1'b0;
    wr_en        = 1'b0;

    // Harmonic m = fcnt+2; product kept wide so large k1 never wraps into range.
    prod    = (KW+3)'(pk_idx_q) * (KW+3)'({1'b0, fcnt_q} + 3'd2);
    rd_addr = prod[KW-1:0];
    rd_val  = rd_ok_q ? rd_q : '0;
    in_rng  = ({1'b0, mag_index} >= SRCH_LO) && ({1'b0, mag_index} <= SRCH_HI);

    case (state_q)
      SYNC: begin
        if (mag_valid && (mag_index == '0)) start = 1'b1;
      end
      CAPTURE: begin
        if (mag_valid) begin
          if (mag_index == exp_q) begin
            accept = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (mag_index == '0) start = 1'b1;
            else state_d = SYNC;
          end
        end
      end
      FETCH: begin
        drop_d  = mag_valid;
        rd_ok_d = (prod <= HARM_MAX);
        fcnt_d  = fcnt_q + 2'd1;
        t2_d    = t3_q;
        t3_d    = t4_q;
        t4_d    = rd_val;
        if (fcnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        drop_d       = mag_valid;
        k1_d         = pk_idx_q;
        h1_d         = pk_val_q;
        h2_d         = t2_q;
        h3_d         = t3_q;
        h4_d         = t4_q;
        h5_d         = rd_val;
        harm_valid_d = 1'b1;
        state_d      = SYNC;
      end
      default: state_d = SYNC;
    endcase

    pk_base = start ? '0 : pk_val_q;
    if (start) begin
      state_d  = CAPTURE;
      exp_d    = KW'(1);
      pk_val_d = '0;
      pk_idx_d = KW'(KMIN);
      fcnt_d   = 2'd0;
    end
    if (accept) begin
      exp_d  = exp_q + KW'(1);
      fcnt_d = 2'd0;
      if (mag_index == LAST_IDX) state_d = FETCH;
    end
    if (start || accept) begin
      wr_en = 1'b1;
      if (in_rng && (mag_data > pk_base)) begin
        pk_val_d = mag_data;
        pk_idx_d = mag_index;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[mag_index] <= mag_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      exp_q        <= '0;
      pk_idx_q     <= '0;
      pk_val_q     <= '0;
      fcnt_q       <= '0;
      rd_ok_q      <= 1'b0;
      t2_q         <= '0;
      t3_q         <= '0;
      t4_q         <= '0;
      k1_q         <= '0;
      h1_q         <= '0;
      h2_q         <= '0;
      h3_q         <= '0;
      h4_q         <= '0;
      h5_q         <= '0;
      harm_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      pk_idx_q     <= pk_idx_d;
      pk_val_q     <= pk_val_d;
      fcnt_q       <= fcnt_d;
      rd_ok_q      <= rd_ok_d;
      t2_q         <= t2_d;
      t3_q         <= t3_d;
      t4_q         <= t4_d;
      k1_q         <= k1_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      h3_q         <= h3_d;
      h4_q         <= h4_d;
      h5_q         <= h5_d;
      harm_valid_q <= harm_valid_d;
      frame_err_q  <= frame_err_d;
      drop_q       <= drop_d;
    end
  end

  assign k1         = k1_q;
  assign h1         = h1_q;
  assign h2         = h2_q;
  assign h3         = h3_q;
  assign h4         = h4_q;
  assign h5         = h5_q;
  assign harm_valid = harm_valid_q;
  assign frame_err  = frame_err_q;
  assign drop       = drop_q;
  assign busy       = (state_q == FETCH) || (state_q == DONE);

endmodule
